// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one SDRAM controller port between two burst clients.
// Each grant covers exactly one BURST_LEN-word burst; acks and beats reach only the owner.
module mem_port_arbiter #(
    parameter int AW        = 25,
    parameter int DW        = 32,
    parameter int BURST_LEN = 8,
    parameter int CW        = 4
) (
    input  logic          mem_clk,
    input  logic          reset,
    input  logic          c0_req,
    input  logic          c1_req,
    input  logic          c0_we,
    input  logic          c1_we,
    input  logic [AW-1:0] c0_addr,
    input  logic [AW-1:0] c1_addr,
    input  logic [DW-1:0] c0_wdata,
    input  logic [DW-1:0] c1_wdata,
    output logic          c0_gnt,
    output logic          c1_gnt,
    output logic          c0_ack,
    output logic          c1_ack,
    output logic          c0_data_next,
    output logic          c1_data_next,
    output logic          c0_rd_valid,
    output logic          c1_rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          mem_idle,
    input  logic          mem_ack,
    input  logic          mem_data_next,
    input  logic          mem_rd_valid,
    input  logic [DW-1:0] mem_rd_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_req,
    output logic          mem_rd_req,
    output logic [DW-1:0] mem_wr_data,
    output logic          busy,
    output logic          proto_err
);

    typedef enum logic [1:0] {IDLE, CMD, XFER} state_t;

    state_t        state, state_nxt;
    logic [1:0]    gnt, gnt_nxt;
    logic          rr_last, rr_last_nxt;
    logic          we, we_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic          wr_req, wr_req_nxt;
    logic          rd_req, rd_req_nxt;
    logic [CW-1:0] beat_cnt, beat_cnt_nxt;
    logic          err, err_nxt;
    logic          pick;
    logic          xfer;
    logic          beat;
    logic          last_beat;

    assign xfer      = (state == XFER);
    assign beat      = xfer && (we ? mem_data_next : mem_rd_valid);
    assign last_beat = beat && (beat_cnt == CW'(BURST_LEN - 1));

    // On a tie the client that did not own the previous burst wins.
    always_comb begin
        pick = c1_req;
        if (c0_req && c1_req)
            pick = ~rr_last;
    end

    // Strays are flagged but otherwise leave the burst untouched.
    assign err_nxt = err
                   | (mem_ack && (state != CMD))
                   | (mem_data_next && !(xfer && we))
                   | (mem_rd_valid && !(xfer && !we));

    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt;
        rr_last_nxt  = rr_last;
        we_nxt       = we;
        addr_nxt     = addr;
        wr_req_nxt   = wr_req;
        rd_req_nxt   = rd_req;
        beat_cnt_nxt = beat_cnt;
        case (state)
            IDLE: begin
                if (mem_idle && (c0_req || c1_req)) begin
                    gnt_nxt    = pick ? 2'b10 : 2'b01;
                    we_nxt     = pick ? c1_we : c0_we;
                    addr_nxt   = pick ? c1_addr : c0_addr;
                    wr_req_nxt = we_nxt;
                    rd_req_nxt = ~we_nxt;
                    state_nxt  = CMD;
                end
            end
            CMD: begin
                if (mem_ack) begin
                    wr_req_nxt   = 1'b0;
                    rd_req_nxt   = 1'b0;
                    beat_cnt_nxt = '0;
                    state_nxt    = XFER;
                end
            end
            XFER: begin
                if (last_beat) begin
                    gnt_nxt     = 2'b00;
                    rr_last_nxt = gnt[1];
                    state_nxt   = IDLE;
                end else if (beat) begin
                    beat_cnt_nxt = beat_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            rr_last  <= 1'b1;
            we       <= 1'b0;
            addr     <= '0;
            wr_req   <= 1'b0;
            rd_req   <= 1'b0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            rr_last  <= rr_last_nxt;
            we       <= we_nxt;
            addr     <= addr_nxt;
            wr_req   <= wr_req_nxt;
            rd_req   <= rd_req_nxt;
            beat_cnt <= beat_cnt_nxt;
            err      <= err_nxt;
        end
    end

    assign c0_gnt       = gnt[0];
    assign c1_gnt       = gnt[1];
    assign c0_ack       = mem_ack & gnt[0] & (state == CMD);
    assign c1_ack       = mem_ack & gnt[1] & (state == CMD);
    assign c0_data_next = mem_data_next & gnt[0] & we & xfer;
    assign c1_data_next = mem_data_next & gnt[1] & we & xfer;
    assign c0_rd_valid  = mem_rd_valid & gnt[0] & ~we & xfer;
    assign c1_rd_valid  = mem_rd_valid & gnt[1] & ~we & xfer;
    assign rd_data      = mem_rd_data;
    assign mem_addr     = addr;
    assign mem_wr_req   = wr_req;
    assign mem_rd_req   = rd_req;
    assign mem_wr_data  = gnt[0] ? c0_wdata : (gnt[1] ? c1_wdata : '0);
    assign busy         = (state != IDLE);
    assign proto_err    = err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: scenario tasks plus a randomized run checked against
// a transaction-level model of the round-robin and burst-routing rules.
module tb_mem_port_arbiter;

    localparam int AW = 25;
    localparam int DW = 32;
    localparam int BL = 8;
    localparam int CW = 4;

    logic          mem_clk = 1'b0;
    logic          reset = 1'b0;
    logic          c0_req, c1_req, c0_we, c1_we;
    logic [AW-1:0] c0_addr, c1_addr;
    logic [DW-1:0] c0_wdata, c1_wdata;
    logic          c0_gnt, c1_gnt, c0_ack, c1_ack;
    logic          c0_data_next, c1_data_next, c0_rd_valid, c1_rd_valid;
    logic [DW-1:0] rd_data;
    logic          mem_idle, mem_ack, mem_data_next, mem_rd_valid;
    logic [DW-1:0] mem_rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_req, mem_rd_req;
    logic [DW-1:0] mem_wr_data;
    logic          busy, proto_err;

    int checks = 0;
    int failures = 0;

    int obs_strobe, obs_wd_ok, obs_rd_ok, obs_stray_routed;
    int obs_ack [2];
    int obs_dn [2];
    int obs_rv [2];
    bit obs_hold_ok, obs_end_ok;

    mem_port_arbiter #(.AW(AW), .DW(DW), .BURST_LEN(BL), .CW(CW)) dut (
        .mem_clk(mem_clk), .reset(reset),
        .c0_req(c0_req), .c1_req(c1_req), .c0_we(c0_we), .c1_we(c1_we),
        .c0_addr(c0_addr), .c1_addr(c1_addr), .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
        .c0_gnt(c0_gnt), .c1_gnt(c1_gnt), .c0_ack(c0_ack), .c1_ack(c1_ack),
        .c0_data_next(c0_data_next), .c1_data_next(c1_data_next),
        .c0_rd_valid(c0_rd_valid), .c1_rd_valid(c1_rd_valid), .rd_data(rd_data),
        .mem_idle(mem_idle), .mem_ack(mem_ack), .mem_data_next(mem_data_next),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .mem_addr(mem_addr), .mem_wr_req(mem_wr_req), .mem_rd_req(mem_rd_req),
        .mem_wr_data(mem_wr_data), .busy(busy), .proto_err(proto_err)
    );

    always #5 mem_clk = ~mem_clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic clear_inputs();
        c0_req = 0; c1_req = 0; c0_we = 0; c1_we = 0;
        c0_addr = '0; c1_addr = '0; c0_wdata = '0; c1_wdata = '0;
        mem_idle = 1; mem_ack = 0; mem_data_next = 0; mem_rd_valid = 0; mem_rd_data = '0;
    endtask

    task automatic apply_reset();
        reset = 0;
        clear_inputs();
        cyc();
        cyc();
        reset = 1;
        cyc();
    endtask

    // Acts as the controller (ack after ack_delay, then BL beats) and as the owning client.
    task automatic serve_burst(input int client, input bit wr, input int ack_delay,
                               input int gap_mode, input int stray, input logic [DW-1:0] base);
        int beats;
        int guard;
        bit pulse;
        bit pat [5];
        pat = '{1, 0, 1, 1, 0};
        obs_strobe = 0; obs_wd_ok = 0; obs_rd_ok = 0; obs_stray_routed = 0;
        obs_ack = '{0, 0}; obs_dn = '{0, 0}; obs_rv = '{0, 0};
        obs_hold_ok = 1;
        for (int k = 0; k <= ack_delay; k++) begin
            if (mem_wr_req || mem_rd_req) obs_strobe++;
            mem_ack = (k == ack_delay);
            #1;
            if (c0_ack) obs_ack[0]++;
            if (c1_ack) obs_ack[1]++;
            cyc();
            mem_ack = 0;
        end
        if (client == 0) c0_req = 0; else c1_req = 0;
        for (int s = 0; s < stray; s++) begin
            if (wr) mem_rd_valid = 1; else mem_data_next = 1;
            #1;
            if (c0_rd_valid || c1_rd_valid || c0_data_next || c1_data_next) obs_stray_routed++;
            cyc();
            mem_rd_valid = 0;
            mem_data_next = 0;
        end
        beats = 0;
        guard = 0;
        while (beats < BL && guard < 400) begin
            case (gap_mode)
                0:       pulse = 1'b1;
                1:       pulse = pat[guard % 5];
                default: pulse = ($urandom_range(2) != 0);
            endcase
            if (client == 0) begin
                c0_wdata = base + DW'(beats);
                c1_wdata = $urandom;
            end else begin
                c1_wdata = base + DW'(beats);
                c0_wdata = $urandom;
            end
            if (wr) mem_data_next = pulse;
            else begin
                mem_rd_valid = pulse;
                mem_rd_data = pulse ? base + DW'(beats) : $urandom;
            end
            #1;
            if (mem_wr_req || mem_rd_req) obs_strobe++;
            if (!busy || !(client == 0 ? c0_gnt : c1_gnt)) obs_hold_ok = 0;
            if (c0_data_next) obs_dn[0]++;
            if (c1_data_next) obs_dn[1]++;
            if (c0_rd_valid) obs_rv[0]++;
            if (c1_rd_valid) obs_rv[1]++;
            if (wr && pulse && mem_wr_data === base + DW'(beats)) obs_wd_ok++;
            if (!wr && pulse && (client == 0 ? c0_rd_valid : c1_rd_valid) &&
                rd_data === base + DW'(beats)) obs_rd_ok++;
            cyc();
            mem_data_next = 0;
            mem_rd_valid = 0;
            if (pulse) beats++;
            guard++;
        end
        obs_end_ok = (beats == BL) && !c0_gnt && !c1_gnt && !busy;
    endtask

    task automatic test_reset();
        reset = 0;
        clear_inputs();
        c0_req = 1; c1_req = 1;
        cyc();
        cyc();
        checks++;
        if ({c0_gnt, c1_gnt, mem_wr_req, mem_rd_req, busy, proto_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {c0_gnt, c1_gnt, mem_wr_req, mem_rd_req, busy, proto_err});
        end
        checks++;
        if (mem_addr !== '0) begin
            failures++; $display("FAIL reset_addr got=%0h exp=0", mem_addr);
        end
        checks++;
        if (mem_wr_data !== '0) begin
            failures++; $display("FAIL reset_wr_data got=%0h exp=0", mem_wr_data);
        end
        c0_req = 0; c1_req = 0;
        reset = 1;
        cyc();
    endtask

    task automatic test_write_burst();
        apply_reset();
        c1_we = 1; c1_addr = 25'h000100; c1_req = 1;
        cyc();
        checks++;
        if ({c0_gnt, c1_gnt, mem_wr_req, mem_rd_req, busy} !== 5'b01101) begin
            failures++;
            $display("FAIL wr_grant got=%b exp=01101", {c0_gnt, c1_gnt, mem_wr_req, mem_rd_req, busy});
        end
        checks++;
        if (mem_addr !== 25'h000100) begin
            failures++; $display("FAIL wr_addr got=%0h exp=100", mem_addr);
        end
        serve_burst(1, 1, 3, 2, 0, 32'h1000_0000);
        checks++;
        if (obs_strobe != 4) begin
            failures++; $display("FAIL wr_strobe_cycles got=%0d exp=4", obs_strobe);
        end
        checks++;
        if (obs_ack[1] != 1 || obs_ack[0] != 0) begin
            failures++; $display("FAIL wr_ack got=%0d/%0d exp=0/1", obs_ack[0], obs_ack[1]);
        end
        checks++;
        if (obs_dn[1] != BL || obs_dn[0] != 0 || obs_rv[0] != 0 || obs_rv[1] != 0) begin
            failures++;
            $display("FAIL wr_beats got=dn%0d/%0d rv%0d/%0d exp=dn0/8 rv0/0",
                     obs_dn[0], obs_dn[1], obs_rv[0], obs_rv[1]);
        end
        checks++;
        if (obs_wd_ok != BL) begin
            failures++; $display("FAIL wr_data got=%0d exp=%0d", obs_wd_ok, BL);
        end
        checks++;
        if (!(obs_hold_ok && obs_end_ok)) begin
            failures++; $display("FAIL wr_gnt_window got=%0b%0b exp=11", obs_hold_ok, obs_end_ok);
        end
        cyc();
        checks++;
        if ({busy, c1_gnt, proto_err} !== 3'b000) begin
            failures++; $display("FAIL wr_after got=%b exp=000", {busy, c1_gnt, proto_err});
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        c0_we = 0; c0_addr = 25'h0002000; c0_req = 1;
        c1_we = 1; c1_addr = 25'h0003000; c1_req = 1;
        cyc();
        checks++;
        if ({c0_gnt, c1_gnt, mem_rd_req, mem_wr_req} !== 4'b1010 || mem_addr !== 25'h0002000) begin
            failures++;
            $display("FAIL rr_first got=%b addr=%0h exp=1010 addr=2000",
                     {c0_gnt, c1_gnt, mem_rd_req, mem_wr_req}, mem_addr);
        end
        serve_burst(0, 0, 1, 0, 0, 32'h2200_0000);
        checks++;
        if (!obs_end_ok || obs_rv[0] != BL || obs_rd_ok != BL || obs_rv[1] != 0) begin
            failures++;
            $display("FAIL rr_burst0 got=end%0b rv%0d ok%0d exp=end1 rv8 ok8", obs_end_ok, obs_rv[0], obs_rd_ok);
        end
        c0_addr = 25'h0002100; c0_req = 1;
        cyc();
        checks++;
        if ({c0_gnt, c1_gnt, mem_wr_req} !== 3'b011 || mem_addr !== 25'h0003000) begin
            failures++;
            $display("FAIL rr_second got=%b addr=%0h exp=011 addr=3000", {c0_gnt, c1_gnt, mem_wr_req}, mem_addr);
        end
        serve_burst(1, 1, 0, 0, 0, 32'h3300_0000);
        checks++;
        if (!obs_end_ok || obs_dn[1] != BL) begin
            failures++; $display("FAIL rr_burst1 got=end%0b dn%0d exp=end1 dn8", obs_end_ok, obs_dn[1]);
        end
        cyc();
        checks++;
        if ({c0_gnt, c1_gnt, mem_rd_req} !== 3'b101 || mem_addr !== 25'h0002100) begin
            failures++;
            $display("FAIL rr_third got=%b addr=%0h exp=101 addr=2100", {c0_gnt, c1_gnt, mem_rd_req}, mem_addr);
        end
        serve_burst(0, 0, 2, 2, 0, 32'h4400_0000);
        checks++;
        if (!obs_end_ok || obs_rv[0] != BL) begin
            failures++; $display("FAIL rr_burst2 got=end%0b rv%0d exp=end1 rv8", obs_end_ok, obs_rv[0]);
        end
    endtask

    task automatic test_read_gaps();
        c0_we = 0; c0_addr = 25'h0000040; c0_req = 1;
        cyc();
        checks++;
        if ({c0_gnt, mem_rd_req} !== 2'b11) begin
            failures++; $display("FAIL gap_grant got=%b exp=11", {c0_gnt, mem_rd_req});
        end
        serve_burst(0, 0, 0, 1, 0, 32'hA5A5_0000);
        checks++;
        if (obs_rv[0] != BL || obs_rd_ok != BL) begin
            failures++; $display("FAIL gap_rd_valid got=%0d ok%0d exp=8 ok8", obs_rv[0], obs_rd_ok);
        end
        checks++;
        if (obs_rv[1] != 0 || obs_dn[0] != 0 || obs_dn[1] != 0 || !obs_end_ok) begin
            failures++;
            $display("FAIL gap_isolation got=rv1_%0d dn%0d/%0d end%0b exp=0 0/0 1",
                     obs_rv[1], obs_dn[0], obs_dn[1], obs_end_ok);
        end
    endtask

    task automatic test_mem_idle();
        int bad;
        bad = 0;
        mem_idle = 0;
        c1_we = 1; c1_addr = 25'h0000777; c1_req = 1;
        repeat (10) begin
            cyc();
            if (c0_gnt || c1_gnt || mem_wr_req || mem_rd_req || busy) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL idle_hold got=%0d exp=0", bad);
        end
        mem_idle = 1;
        cyc();
        checks++;
        if ({c1_gnt, mem_wr_req} !== 2'b11) begin
            failures++; $display("FAIL idle_release got=%b exp=11", {c1_gnt, mem_wr_req});
        end
        serve_burst(1, 1, 0, 0, 0, 32'h5500_0000);
        checks++;
        if (!obs_end_ok) begin
            failures++; $display("FAIL idle_burst got=%0b exp=1", obs_end_ok);
        end
    endtask

    task automatic test_proto_err();
        apply_reset();
        mem_ack = 1;
        #1;
        checks++;
        if ({c0_ack, c1_ack} !== 2'b00) begin
            failures++; $display("FAIL perr_ack_routed got=%b exp=00", {c0_ack, c1_ack});
        end
        cyc();
        mem_ack = 0;
        checks++;
        if ({proto_err, busy, c0_gnt, c1_gnt} !== 4'b1000) begin
            failures++; $display("FAIL perr_set got=%b exp=1000", {proto_err, busy, c0_gnt, c1_gnt});
        end
        repeat (3) cyc();
        checks++;
        if (proto_err !== 1'b1) begin
            failures++; $display("FAIL perr_sticky got=%b exp=1", proto_err);
        end
        c0_we = 1; c0_addr = 25'h0001234; c0_req = 1;
        cyc();
        serve_burst(0, 1, 1, 2, 0, 32'h6600_0000);
        checks++;
        if (obs_dn[0] != BL || obs_wd_ok != BL || !obs_end_ok || proto_err !== 1'b1) begin
            failures++;
            $display("FAIL perr_burst got=dn%0d wd%0d end%0b err%b exp=dn8 wd8 end1 err1",
                     obs_dn[0], obs_wd_ok, obs_end_ok, proto_err);
        end
    endtask

    task automatic test_wrong_beat();
        apply_reset();
        c0_we = 1; c0_addr = 25'h0000300; c0_req = 1;
        cyc();
        serve_burst(0, 1, 0, 0, 3, 32'h7700_0000);
        checks++;
        if (obs_stray_routed != 0 || !obs_hold_ok || !obs_end_ok || proto_err !== 1'b1) begin
            failures++;
            $display("FAIL wrong_rd_in_wr got=routed%0d hold%0b end%0b err%b exp=0 1 1 1",
                     obs_stray_routed, obs_hold_ok, obs_end_ok, proto_err);
        end
        apply_reset();
        c1_we = 0; c1_addr = 25'h0000400; c1_req = 1;
        cyc();
        serve_burst(1, 0, 1, 0, 2, 32'h8800_0000);
        checks++;
        if (obs_stray_routed != 0 || !obs_hold_ok || !obs_end_ok || proto_err !== 1'b1) begin
            failures++;
            $display("FAIL wrong_dn_in_rd got=routed%0d hold%0b end%0b err%b exp=0 1 1 1",
                     obs_stray_routed, obs_hold_ok, obs_end_ok, proto_err);
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        c1_we = 1; c1_addr = 25'h0000abc; c1_req = 1;
        cyc();
        mem_ack = 1;
        cyc();
        mem_ack = 0; c1_req = 0;
        repeat (3) begin
            mem_data_next = 1;
            cyc();
        end
        mem_data_next = 1;
        #1;
        reset = 0;
        #1;
        checks++;
        if ({c0_gnt, c1_gnt, mem_wr_req, mem_rd_req, busy, proto_err, c1_data_next} !== 7'b0 ||
            mem_addr !== '0) begin
            failures++;
            $display("FAIL midrst_async got=%b addr=%0h exp=0000000 addr=0",
                     {c0_gnt, c1_gnt, mem_wr_req, mem_rd_req, busy, proto_err, c1_data_next}, mem_addr);
        end
        mem_data_next = 0;
        cyc();
        checks++;
        if ({c0_gnt, c1_gnt, mem_wr_req, mem_rd_req, busy, proto_err} !== 6'b0) begin
            failures++;
            $display("FAIL midrst_next got=%b exp=000000",
                     {c0_gnt, c1_gnt, mem_wr_req, mem_rd_req, busy, proto_err});
        end
        c0_we = 0; c0_addr = 25'h0000111; c0_req = 1;
        c1_we = 1; c1_addr = 25'h0000222; c1_req = 1;
        reset = 1;
        cyc();
        checks++;
        if ({c0_gnt, c1_gnt, mem_rd_req} !== 3'b101 || mem_addr !== 25'h0000111) begin
            failures++;
            $display("FAIL midrst_tie got=%b addr=%0h exp=101 addr=111", {c0_gnt, c1_gnt, mem_rd_req}, mem_addr);
        end
        serve_burst(0, 0, 0, 0, 0, 32'h9900_0000);
        cyc();
        checks++;
        if ({c0_gnt, c1_gnt, mem_wr_req} !== 3'b011) begin
            failures++; $display("FAIL midrst_follow got=%b exp=011", {c0_gnt, c1_gnt, mem_wr_req});
        end
        serve_burst(1, 1, 0, 0, 0, 32'h9a00_0000);
    endtask

    // Each iteration starts idle; the model predicts the winner from the pending requests.
    task automatic test_random();
        int left [2];
        int last_winner;
        int win;
        int iter;
        bit exp_we;
        bit ok;
        logic [AW-1:0] exp_addr;
        apply_reset();
        left = '{5, 5};
        last_winner = 1;
        iter = 0;
        while ((left[0] > 0 || left[1] > 0) && iter < 500) begin
            iter++;
            if (!c0_req && left[0] > 0 && $urandom_range(3) == 0) begin
                c0_req = 1; c0_we = 1'($urandom_range(1)); c0_addr = AW'($urandom);
            end
            if (!c1_req && left[1] > 0 && $urandom_range(3) == 0) begin
                c1_req = 1; c1_we = 1'($urandom_range(1)); c1_addr = AW'($urandom);
            end
            mem_idle = ($urandom_range(3) != 0);
            if (!mem_idle || (!c0_req && !c1_req)) win = -1;
            else if (c0_req && c1_req) win = 1 - last_winner;
            else win = c1_req ? 1 : 0;
            exp_we = (win == 1) ? c1_we : c0_we;
            exp_addr = (win == 1) ? c1_addr : c0_addr;
            cyc();
            checks++;
            if (win < 0) begin
                if (c0_gnt || c1_gnt || busy) begin
                    failures++;
                    $display("FAIL rand_no_grant got=%b exp=000", {c0_gnt, c1_gnt, busy});
                end
            end else if ({c0_gnt, c1_gnt} !== (win == 0 ? 2'b10 : 2'b01) ||
                         mem_wr_req !== exp_we || mem_rd_req !== !exp_we || mem_addr !== exp_addr) begin
                failures++;
                $display("FAIL rand_grant got=gnt%b wr%b addr=%0h exp=client%0d wr%b addr=%0h",
                         {c0_gnt, c1_gnt}, mem_wr_req, mem_addr, win, exp_we, exp_addr);
            end else begin
                serve_burst(win, exp_we, $urandom_range(3), 2, 0, $urandom);
                ok = obs_end_ok && obs_hold_ok && obs_ack[win] == 1 && obs_ack[1-win] == 0 &&
                     obs_dn[win] == (exp_we ? BL : 0) && obs_dn[1-win] == 0 &&
                     obs_rv[win] == (exp_we ? 0 : BL) && obs_rv[1-win] == 0 &&
                     (exp_we ? obs_wd_ok : obs_rd_ok) == BL;
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL rand_burst client%0d we%b got=end%0b ack%0d/%0d dn%0d/%0d rv%0d/%0d exp=one burst of %0d",
                             win, exp_we, obs_end_ok, obs_ack[0], obs_ack[1], obs_dn[0], obs_dn[1],
                             obs_rv[0], obs_rv[1], BL);
                end
                last_winner = win;
                left[win]--;
            end
        end
        checks++;
        if (left[0] != 0 || left[1] != 0 || proto_err !== 1'b0) begin
            failures++;
            $display("FAIL rand_complete got=left%0d/%0d err%b exp=0/0 err0", left[0], left[1], proto_err);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_write_burst();
        test_round_robin();
        test_read_gaps();
        test_mem_idle();
        test_proto_err();
        test_wrong_beat();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single SDRAM controller command/data port between two burst clients.
- Client 0 is the display read stream. Client 1 is the FTDI block-copy writer.
- Each grant covers exactly one BURST_LEN-word burst. Arbitration is round-robin.
- Routes ack and per-word beats (mem_data_next, mem_rd_valid) only to the granted client.

Parameters:
AW, 25, memory word address width
DW, 32, data width
BURST_LEN, 8, words per granted burst (>=1)
CW, 4, beat counter width; must satisfy 2^CW > BURST_LEN

Ports:
mem_clk  in  1  system/memory clock; all logic on posedge
reset  in  1  asynchronous, active-low reset
c0_req, c1_req  in  1  burst request; must be held until cN_ack
c0_we, c1_we  in  1  1=write burst, 0=read burst
c0_addr, c1_addr  in  AW  burst start address
c0_wdata, c1_wdata  in  DW  write word for the current beat
c0_gnt, c1_gnt  out  1  registered grant, one-hot or zero
c0_ack, c1_ack  out  1  controller accepted this client's command
c0_data_next, c1_data_next  out  1  write beat consumed; advance source
c0_rd_valid, c1_rd_valid  out  1  mem_rd_data valid for this client
rd_data  out  DW  mem_rd_data passed through to both clients
mem_idle  in  1  controller ready for a new command
mem_ack  in  1  command accepted
mem_data_next  in  1  write word consumed
mem_rd_valid  in  1  read word valid
mem_rd_data  in  DW  read data
mem_addr  out  AW  latched address of granted burst
mem_wr_req, mem_rd_req  out  1  registered command strobes
mem_wr_data  out  DW  wdata of granted client (combinational mux)
busy  out  1  state != IDLE
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (reset=0, async): state=IDLE; rr_last=1 so client 0 wins the first tie. All gnt, ack, req strobes, busy and proto_err = 0. mem_addr=0. Beat count=0.
- IDLE:
  - Acts when mem_idle=1 and any cN_req=1.
  - If only one client requests, that client wins.
  - If both request, the client != rr_last wins.
  - At the next edge: gnt goes high, mem_addr and we are latched, mem_wr_req or mem_rd_req = 1, go to CMD. Latency from req sampled to strobe is 1 cycle.
  - If mem_idle=0, nothing is granted.
- CMD:
  - The strobe stays high until mem_ack.
  - On mem_ack, at the same edge: strobe is cleared, beat count cleared, go to XFER.
  - cN_ack = mem_ack & gnt_N & (state==CMD), combinational, so the client sees a single-cycle pulse.
  - Client req deassertion after grant is ignored; the command is committed.
- XFER:
  - Beats are mem_data_next if we=1, mem_rd_valid if we=0.
  - cN_data_next = mem_data_next & gnt_N & we & XFER, combinational.
  - cN_rd_valid = mem_rd_valid & gnt_N & ~we & XFER, combinational.
  - Each beat increments the count.
  - The beat with count == BURST_LEN-1 ends the burst. At that edge: gnt clears, rr_last = granted client, go to IDLE.
- mem_wr_data = granted client's wdata. It is undefined/don't-care when there is no grant; drive 0.
- Fairness: a client re-requesting immediately after its burst loses to a pending other client. IDLE lasts at least 1 cycle between bursts.
- Protocol errors: proto_err is set, sticky until reset, on any of:
  - mem_ack outside CMD
  - mem_data_next outside a write XFER
  - mem_rd_valid outside a read XFER
  The offending event is otherwise ignored; no state change.
- Beats of the wrong type during XFER (e.g. mem_rd_valid during a write burst) set proto_err and do not count.
- Reset asserted mid-burst: immediate return to the reset values. The controller-side burst is abandoned; no recovery is attempted.

Test Plan:
- c1 alone, we=1, addr=0x000100, BURST_LEN=8, ack 3 cycles after strobe, 8 data_next pulses -> mem_wr_req high exactly 4 cycles; 8 c1_data_next pulses; c1_gnt drops on the 8th beat edge; busy=0 one cycle later.
- Both req together from reset -> c0 wins; after its 8 read beats c1 is granted; then c0 re-requests -> c0 wins next. Grants alternate 0,1,0.
- c0 read burst with mem_rd_valid gaps (pattern 1,0,1,1,0,...) and data 0xA5A50000+i -> c0_rd_valid pulses exactly 8 times with matching rd_data; c1_rd_valid stays 0.
- mem_idle=0 with c1_req=1 for 10 cycles -> no gnt or strobe. mem_idle rises -> gnt and mem_wr_req one cycle later.
- Stray mem_ack while IDLE -> proto_err=1 and stays 1; subsequent normal burst still completes correctly.
- reset pulled low during beat 4 of a write burst -> next cycle all outputs 0 and state=IDLE. After release, a tied request grants c0 first.
